// File: rtl/sr_latch_bank_ctrl.sv
// Round-robin sequencer driving a bank of gated SR latches through setup/enable/hold phases.
// Optional Q readback compare is enabled by defining SRL_CTRL_READBACK_EN.
module sr_latch_bank_ctrl #(
    parameter int unsigned N_LATCH   = 4,
    parameter int unsigned AW        = 2,
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned PULSE_CYC = 4,
    parameter int unsigned HOLD_CYC  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [2*AW-1:0]   req_addr,
    input  logic [3:0]        req_op,
    output logic [N_LATCH-1:0] latch_s,
    output logic [N_LATCH-1:0] latch_r,
    output logic [N_LATCH-1:0] latch_e,
    input  logic [N_LATCH-1:0] latch_q,
    output logic [N_LATCH-1:0] shadow_q,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned MaxSp  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int unsigned MaxCyc = (MaxSp > HOLD_CYC) ? MaxSp : HOLD_CYC;
    localparam int unsigned CntW   = $clog2(MaxCyc + 1);

    localparam logic [CntW-1:0] SetupLoad = CntW'(SETUP_CYC - 1);
    localparam logic [CntW-1:0] PulseLoad = CntW'(PULSE_CYC - 1);
    localparam logic [CntW-1:0] HoldLoad  = CntW'(HOLD_CYC - 1);

    localparam logic [1:0] OpNop   = 2'b00;
    localparam logic [1:0] OpSet   = 2'b01;
    localparam logic [1:0] OpReset = 2'b10;

    typedef enum logic [1:0] {StIdle, StSetup, StEnable, StHold} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic                op_set_q, op_set_d;
    logic                last_grant_q, last_grant_d;
    logic [N_LATCH-1:0]  shadow_state_q, shadow_state_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic [1:0]          grant;
    logic [AW-1:0]       sel_addr;
    logic [1:0]          sel_op;
    logic                addr_ok;
    logic [N_LATCH-1:0]  sel_mask;
    logic                drive_sr;
    logic                rb_mismatch;

`ifdef SRL_CTRL_READBACK_EN
    logic [N_LATCH-1:0]  q_sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_sync_q <= '0;
        end else begin
            q_sync_q <= latch_q;
        end
    end

    // Expected post-command level is 1 for set, 0 for reset.
    assign rb_mismatch = (|(q_sync_q & sel_mask)) != op_set_q;
`else
    logic unused_latch_q;
    assign unused_latch_q = ^latch_q;
    assign rb_mismatch    = 1'b0;
`endif

    // Ties go to the requester that was not granted last; gated off while in reset.
    always_comb begin
        grant = 2'b00;
        if (rst_n && state_q == StIdle) begin
            if (req_valid == 2'b11) begin
                grant = last_grant_q ? 2'b01 : 2'b10;
            end else begin
                grant = req_valid;
            end
        end
    end

    assign req_ready = grant;
    assign sel_addr  = grant[1] ? req_addr[2*AW-1:AW] : req_addr[AW-1:0];
    assign sel_op    = grant[1] ? req_op[3:2] : req_op[1:0];
    assign addr_ok   = 32'(sel_addr) < N_LATCH;
    assign sel_mask  = N_LATCH'(1) << addr_q;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        addr_d         = addr_q;
        op_set_d       = op_set_q;
        last_grant_d   = last_grant_q;
        shadow_state_d = shadow_state_q;
        done_d         = 1'b0;
        err_d          = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (|grant) begin
                    last_grant_d = grant[1];
                    addr_d       = sel_addr;
                    if ((sel_op == OpSet || sel_op == OpReset) && addr_ok) begin
                        op_set_d = (sel_op == OpSet);
                        cnt_d    = SetupLoad;
                        state_d  = StSetup;
                    end else if (sel_op == OpNop) begin
                        done_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StSetup: begin
                if (cnt_q == '0) begin
                    cnt_d   = PulseLoad;
                    state_d = StEnable;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StEnable: begin
                if (cnt_q == '0) begin
                    cnt_d   = HoldLoad;
                    state_d = StHold;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StHold: begin
                if (cnt_q == '0) begin
                    shadow_state_d = op_set_q ? (shadow_state_q | sel_mask)
                                              : (shadow_state_q & ~sel_mask);
                    done_d  = 1'b1;
                    err_d   = rb_mismatch;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            addr_q         <= '0;
            op_set_q       <= 1'b0;
            last_grant_q   <= 1'b1;
            shadow_state_q <= '0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            addr_q         <= addr_d;
            op_set_q       <= op_set_d;
            last_grant_q   <= last_grant_d;
            shadow_state_q <= shadow_state_d;
            done_q         <= done_d;
            err_q          <= err_d;
        end
    end

    // S/R span SETUP and ENABLE so they are stable for the whole E pulse.
    assign drive_sr = (state_q == StSetup) || (state_q == StEnable);
    assign latch_s  = (drive_sr && op_set_q)  ? sel_mask : '0;
    assign latch_r  = (drive_sr && !op_set_q) ? sel_mask : '0;
    assign latch_e  = (state_q == StEnable)   ? sel_mask : '0;
    assign shadow_q = shadow_state_q;
    assign busy     = (state_q != StIdle);
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_sr_latch_bank_ctrl.sv
// Directed bench for sr_latch_bank_ctrl: reset, single set, contention, illegal/out-of-range,
// reset mid-enable, 200 random commands against a cycle model, and the readback option.
module tb_sr_latch_bank_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req_valid, req_ready;
    logic [3:0] req_addr, req_op;
    logic [3:0] latch_s, latch_r, latch_e, latch_q, shadow_q;
    logic       busy, done, err;

    logic [1:0] valid2, ready2;
    logic [3:0] addr2, op2;
    logic [2:0] s2, r2, e2, shadow2;
    logic [2:0] q2 = 3'b000;
    logic       busy2, done2, err2;

    logic [3:0] q_model = 4'b0000;
    logic       tie_q1;
    logic [3:0] prev_s = 4'b0000, prev_r = 4'b0000;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sr_latch_bank_ctrl dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_op(req_op), .latch_s(latch_s), .latch_r(latch_r),
        .latch_e(latch_e), .latch_q(latch_q), .shadow_q(shadow_q), .busy(busy),
        .done(done), .err(err)
    );

    sr_latch_bank_ctrl #(.N_LATCH(3), .AW(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(valid2), .req_ready(ready2),
        .req_addr(addr2), .req_op(op2), .latch_s(s2), .latch_r(r2),
        .latch_e(e2), .latch_q(q2), .shadow_q(shadow2), .busy(busy2),
        .done(done2), .err(err2)
    );

    // Behavioural latch bank feeding Q back; bit 1 can be stuck low.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (latch_e[i] === 1'b1) begin
                if (latch_s[i] === 1'b1) q_model[i] <= 1'b1;
                else if (latch_r[i] === 1'b1) q_model[i] <= 1'b0;
            end
        end
    end
    assign latch_q = tie_q1 ? (q_model & 4'b1101) : q_model;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chk("inv_s_and_r", 32'(latch_s & latch_r), 0);
        chk("inv_e_onehot", 32'($countones(latch_e) <= 1), 1);
        chk("inv_ready_onehot", 32'(req_ready != 2'b11), 1);
        if (|latch_e) begin
            chk("inv_s_stable", 32'(latch_s), 32'(prev_s));
            chk("inv_r_stable", 32'(latch_r), 32'(prev_r));
        end
        prev_s = latch_s;
        prev_r = latch_r;
    endtask

    task automatic wait_done(input string tag);
        int lat = 1;
        while (done !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        chk(tag, lat, 9);
    endtask

    initial begin
        int cnt, pend_done, pend_err, hs_cnt, guard, cur, ed, ee;
        logic lg;
        logic [1:0] er, cop, caddr, o;
        logic [3:0] exp_sh, mask, es, ee4;

        rst_n = 1'b0; req_valid = 2'b00; req_addr = 4'h0; req_op = 4'h0;
        valid2 = 2'b00; addr2 = 4'h0; op2 = 4'h0; tie_q1 = 1'b0;

        // Reset state.
        tick();
        chk("rst_latch_s", 32'(latch_s), 0);
        chk("rst_latch_r", 32'(latch_r), 0);
        chk("rst_latch_e", 32'(latch_e), 0);
        chk("rst_shadow", 32'(shadow_q), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        req_valid = 2'b01;
        #1 chk("rst_ready", 32'(req_ready), 0);
        tick();
        tick();

        // Single set of latch 2 from requester 0.
        rst_n = 1'b1; req_addr = 4'b0010; req_op = 4'b0001;
        #1 chk("t1_ready", 32'(req_ready), 32'b01);
        tick();
        req_valid = 2'b00;
        for (int k = 1; k <= 9; k++) begin
            es  = (k <= 6) ? 4'b0100 : 4'b0000;
            ee4 = (k >= 3 && k <= 6) ? 4'b0100 : 4'b0000;
            chk("t1_latch_s", 32'(latch_s), 32'(es));
            chk("t1_latch_r", 32'(latch_r), 0);
            chk("t1_latch_e", 32'(latch_e), 32'(ee4));
            chk("t1_busy", 32'(busy), 32'(k <= 8));
            chk("t1_done", 32'(done), 32'(k == 9));
            chk("t1_shadow", 32'(shadow_q), (k == 9) ? 32'b0100 : 32'b0);
            if (k < 9) tick();
        end
        tick();
        chk("t1_done_clear", 32'(done), 0);

        // Contention: req0 sets 0, req1 resets 1; grants alternate starting with 0.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; req_addr = 4'b0100; req_op = 4'b1001; req_valid = 2'b11;
        #1;
        for (int n = 0; n < 4; n++) begin
            int w = 0;
            while (req_ready == 2'b00 && w < 20) begin
                tick();
                w++;
            end
            chk("ctn_wait", 32'(w < 20), 1);
            chk("ctn_grant", 32'(req_ready), (n % 2 == 1) ? 32'b10 : 32'b01);
            tick();
            wait_done("ctn_latency");
        end
        req_valid = 2'b00;
        chk("ctn_shadow", 32'(shadow_q), 32'b0001);

        // Illegal op and out-of-range address on the 3-latch instance, then a nop.
        valid2 = 2'b01; op2 = 4'b0011; addr2 = 4'b0000;
        #1 chk("ill_ready", 32'(ready2), 32'b01);
        tick();
        op2 = 4'b0001; addr2 = 4'b0011;
        chk("ill_err", 32'(err2), 1);
        chk("ill_done", 32'(done2), 0);
        chk("ill_busy", 32'(busy2), 0);
        chk("ill_latches", 32'({s2, r2, e2}), 0);
        #1 chk("oor_ready", 32'(ready2), 32'b01);
        tick();
        op2 = 4'b0000; addr2 = 4'b0000;
        chk("oor_err", 32'(err2), 1);
        chk("oor_busy", 32'(busy2), 0);
        chk("oor_latches", 32'({s2, r2, e2}), 0);
        tick();
        valid2 = 2'b00;
        chk("nop_done", 32'(done2), 1);
        chk("nop_err", 32'(err2), 0);
        chk("nop_busy", 32'(busy2), 0);
        tick();
        chk("nop_done_clear", 32'({done2, err2}), 0);

        // Reset during the second ENABLE cycle.
        req_valid = 2'b10; req_addr = 4'b1100; req_op = 4'b0100;
        #1 chk("rme_ready", 32'(req_ready), 32'b10);
        tick();
        req_valid = 2'b00;
        for (int k = 0; k < 3; k++) tick();
        chk("rme_enable", 32'(latch_e), 32'b1000);
        rst_n = 1'b0;
        tick();
        chk("rme_latch_e", 32'(latch_e), 0);
        chk("rme_latch_s", 32'(latch_s), 0);
        chk("rme_busy", 32'(busy), 0);
        chk("rme_shadow", 32'(shadow_q), 0);
        rst_n = 1'b1; req_valid = 2'b01; req_addr = 4'b0000; req_op = 4'b0010;
        #1 chk("rme_new_ready", 32'(req_ready), 32'b01);
        tick();
        req_valid = 2'b00;
        chk("rme_new_busy", 32'(busy), 1);
        chk("rme_new_r", 32'(latch_r), 32'b0001);
        wait_done("rme_new_latency");

        // 200 random commands against a cycle model.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        cnt = 0; pend_done = 0; pend_err = 0; hs_cnt = 0; guard = 0;
        lg = 1'b1; exp_sh = 4'b0000; cop = 2'b01; caddr = 2'b00;
        while (hs_cnt < 200 && guard < 20000) begin
            guard++;
            req_valid = 2'($urandom_range(0, 3));
            req_addr  = 4'($urandom);
            req_op    = 4'($urandom);
            #1;
            er = 2'b00;
            if (cnt == 0) begin
                if (req_valid == 2'b11) er = lg ? 2'b01 : 2'b10;
                else er = req_valid;
            end
            chk("rnd_ready", 32'(req_ready), 32'(er));
            if (er != 2'b00) begin
                lg = er[1];
                o  = er[1] ? req_op[3:2] : req_op[1:0];
                hs_cnt++;
                if (o == 2'b01 || o == 2'b10) begin
                    cnt = 1; cop = o; caddr = er[1] ? req_addr[3:2] : req_addr[1:0];
                end else if (o == 2'b00) begin
                    pend_done = 1;
                end else begin
                    pend_err = 1;
                end
            end
            tick();
            cur = cnt; ed = pend_done; ee = pend_err; pend_done = 0; pend_err = 0;
            mask = 4'b0001 << caddr;
            if (cur == 9) begin
                ed = 1;
                exp_sh = (cop == 2'b01) ? (exp_sh | mask) : (exp_sh & ~mask);
                cnt = 0;
            end else if (cur > 0) begin
                cnt++;
            end
            chk("rnd_done", 32'(done), 32'(ed));
            chk("rnd_err", 32'(err), 32'(ee));
            chk("rnd_busy", 32'(busy), 32'(cur >= 1 && cur <= 8));
            chk("rnd_shadow", 32'(shadow_q), 32'(exp_sh));
            chk("rnd_latch_s", 32'(latch_s),
                (cur >= 1 && cur <= 6 && cop == 2'b01) ? 32'(mask) : 32'b0);
            chk("rnd_latch_r", 32'(latch_r),
                (cur >= 1 && cur <= 6 && cop == 2'b10) ? 32'(mask) : 32'b0);
            chk("rnd_latch_e", 32'(latch_e), (cur >= 3 && cur <= 6) ? 32'(mask) : 32'b0);
        end
        chk("rnd_count", hs_cnt, 200);

        // Set latch 1 while its Q is stuck low.
        req_valid = 2'b00;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; tie_q1 = 1'b1;
        req_valid = 2'b01; req_addr = 4'b0001; req_op = 4'b0001;
        #1;
        tick();
        req_valid = 2'b00;
        wait_done("rb_latency");
`ifdef SRL_CTRL_READBACK_EN
        chk("rb_err", 32'(err), 1);
`else
        chk("rb_err", 32'(err), 0);
`endif
        chk("rb_shadow", 32'(shadow_q), 32'b0010);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sr_latch_bank_ctrl.md
# sr_latch_bank_ctrl

Sequencer and arbiter for a bank of `N_LATCH` gated SR latches. It accepts set/reset commands from two requesters over valid/ready handshakes and arbitrates between them round-robin. For each granted command it drives the addressed latch's S, R and E through a fixed setup/enable/hold sequence. It sits between the Basys3 switch/button front-end logic and the latch bank, and it never presents S=R=1 to any latch.

## Interface

Parameters:
- `N_LATCH`, 4 — number of latches in the bank (1..16).
- `AW`, 2 — command address width; `2**AW >= N_LATCH`.
- `SETUP_CYC`, 2 — cycles S/R are driven with E=0 before enable (>=1).
- `PULSE_CYC`, 4 — cycles E is held high (>=1).
- `HOLD_CYC`, 2 — cycles S/R/E are all low after enable, before the next command (>=1).

Ports:
- `clk` in 1 — single clock; all logic is on its rising edge.
- `rst_n` in 1 — synchronous, active-low reset.
- `req_valid` in 2 — per-requester command valid; bit 0 is requester 0.
- `req_ready` out 2 — per-requester accept; at most one bit high in any cycle.
- `req_addr` in 2*AW — latch index; requester k uses bits [k*AW +: AW].
- `req_op` in 4 — 2-bit opcode per requester: 01=set, 10=reset, 00=nop, 11=illegal.
- `latch_s` out N_LATCH — S drive to each latch.
- `latch_r` out N_LATCH — R drive to each latch.
- `latch_e` out N_LATCH — E drive to each latch.
- `latch_q` in N_LATCH — Q feedback from the bank; used only with the readback feature.
- `shadow_q` out N_LATCH — expected latch state, updated by completed commands.
- `busy` out 1 — high whenever the state is not IDLE.
- `done` out 1 — one-cycle pulse when a command completes.
- `err` out 1 — one-cycle pulse when a command is rejected or fails readback.

## Operation

- FSM states: IDLE, SETUP, ENABLE, HOLD.
- **IDLE**
  - `req_ready[g]` is high for the arbitration winner g only.
  - Arbitration is round-robin: the requester not granted last wins a tie. Last-grant resets to 1, so requester 0 wins the first tie.
  - On the handshake `req_valid[g] & req_ready[g]`, the block latches addr/op/g.
  - op set/reset with addr < N_LATCH → SETUP.
  - op nop → no latch activity; `done` pulses next cycle; stays IDLE.
  - op illegal, or addr >= N_LATCH → `err` pulses next cycle; stays IDLE; last-grant still updates.
- **SETUP:** drive `latch_s[a]=1` (set) or `latch_r[a]=1` (reset); `latch_e=0`. Lasts SETUP_CYC cycles → ENABLE.
- **ENABLE:** S/R unchanged; `latch_e[a]=1`. Lasts PULSE_CYC cycles → HOLD.
- **HOLD:** `latch_s`, `latch_r` and `latch_e` are all 0. Lasts HOLD_CYC cycles.
  - On the last HOLD cycle, `shadow_q[a]` updates (1 for set, 0 for reset) and `done` pulses.
  - → IDLE.
- Only bit `a` of any latch bus is ever nonzero. S and R are never both 1 on the same bit. E never rises in the same cycle that S/R change.
- Phase lengths use one down-counter of width clog2(max(SETUP_CYC,PULSE_CYC,HOLD_CYC)+1).

## Timing

- Reset value of every output is 0.
  - `latch_s`, `latch_r`, `latch_e`, `shadow_q`, `busy`, `done`, `err` and `req_ready` are all 0 in the reset cycle.
  - `req_ready` may go high on the first cycle after `rst_n` rises.
- Reset asserted mid-command: at the next edge `latch_e` drops and every output returns to 0. The physical latch keeps its value, but `shadow_q` is cleared.
- Latency, handshake to `done`: 1 + SETUP_CYC + PULSE_CYC + HOLD_CYC cycles. With the defaults this is 9 cycles.
- Back-to-back: the next handshake can occur in the cycle after `done`.
- `req_ready` is combinational from state, last-grant and `req_valid`.
- A requester may drop `req_valid` before it is accepted; no transaction is recorded.
- Changes to req inputs while busy are ignored.

## Configuration

- `SRL_CTRL_READBACK_EN` defined:
  - On the last HOLD cycle, compare `latch_q[a]` with the expected value.
  - On mismatch, pulse `err` together with `done`. `shadow_q` still takes the expected value.
  - `latch_q` is registered once before the compare.
- Undefined:
  - `latch_q` is unused.
  - `err` pulses only for illegal commands or out-of-range addresses.

## Test plan

- **Reset then single set.** rst_n low 3 cycles, then req0 valid addr=2 op=01.
  - `latch_s`=0100 for 2 cycles; then `latch_e`=0100 for 4 cycles; then all 0 for 2 cycles.
  - `done` fires 9 cycles after the handshake; `shadow_q`=0100.
- **Contention.** Both requesters valid continuously: req0 sets addr 0, req1 resets addr 1.
  - Grants alternate 0,1,0,1.
  - Each `done` is 9 cycles after its handshake; `req_ready` is never 2'b11.
- **Illegal and out-of-range.** op=11, then addr=3 with N_LATCH=3.
  - `err` pulses 1 cycle after each handshake.
  - `latch_*` stays 0; `busy` stays 0.
- **Reset mid-ENABLE.** rst_n low in the 2nd ENABLE cycle.
  - The next edge has `latch_e`=0, `busy`=0, `shadow_q`=0.
  - A new command is accepted after release.
- **Invariant check over 200 random commands.**
  - (`latch_s` & `latch_r`)==0 every cycle.
  - popcount(`latch_e`)<=1.
  - S/R are stable whenever E is high.
- **With SRL_CTRL_READBACK_EN.** Tie `latch_q[1]`=0 and set addr 1.
  - `done` and `err` pulse in the same cycle; `shadow_q[1]`=1.
